sh7034_ibus_arb: RTL
====================

SH7034_IBUS_ARB -- requirements
Module: sh7034_ibus_arb

Interface
REQ-001 The block SHALL have parameter DMA_MAX_RUN, default 4: the maximum number of consecutive DMAC grants while the CPU is waiting.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  system clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 CE_R, CE_F  in  1 each  rising/falling phase clock enables.
REQ-006 CPU_A[27:0], CPU_DI[31:0], CPU_BA[3:0], CPU_WE, CPU_REQ  in  CPU master request, address, write data, byte lanes and direction.
REQ-007 CPU_DO  out  32  CPU read data; CPU_BUSY  out  1  CPU wait.
REQ-008 DMA_A, DMA_DI, DMA_BA, DMA_WE, DMA_REQ  in; DMA_DO  out  32; DMA_BUSY  out  1: the DMAC master port, with the same widths as the CPU port.
REQ-009 IBUS_A[27:0], IBUS_DO[31:0], IBUS_BA[3:0], IBUS_WE, IBUS_REQ  out  shared peripheral bus, driven towards the UBC and other on-chip slaves.
REQ-010 IBUS_DI[31:0], IBUS_BUSY, IBUS_ACT  in  OR-combined slave read data, wait and address-decode-hit.

Function
REQ-011 The arbiter SHALL use an FSM with states IDLE, GNT_CPU and GNT_DMA, and SHALL update state only on cycles with CE_R=1.
REQ-012 In IDLE: IBUS_REQ=0; IBUS_A/DO/BA/WE=0.
REQ-013 In GNT_x: IBUS_A/DO/BA/WE SHALL combinationally equal master x's A/DI/BA/WE, and IBUS_REQ=1.
REQ-014 Arbitration in IDLE at CE_R:
- DMA_REQ and (RUN<DMA_MAX_RUN or !CPU_REQ) -> GNT_DMA.
- else CPU_REQ -> GNT_CPU.
- else stay IDLE.
REQ-015 An access in GNT_x SHALL complete ("DONE") on a CE_R cycle where IBUS_BUSY=0 or IBUS_ACT=0; at DONE the state SHALL return to IDLE.
REQ-016 An unmapped access (IBUS_ACT=0) SHALL complete with read data 0 and SHALL not hang.
REQ-017 Every grant SHALL cost one IDLE CE_R turnaround, so the minimum is 2 CE_R cycles per access.
REQ-018 Grants SHALL be non-preemptive: the state SHALL leave GNT_x only at DONE or on RST.
REQ-019 A master's BUSY = REQ and not (granted and DONE-condition true this cycle); the condition is combinational and the wait-state count is unbounded while BUSY=1.
REQ-020 Read data:
- When granted and reading, x_DO SHALL be IBUS_DI, muxed combinationally.
- At DONE of a read, IBUS_DI (or 0 if IBUS_ACT=0) SHALL be latched and x_DO SHALL hold the latched value until x's next read DONE.
- A write DONE SHALL not alter x_DO.
REQ-021 RUN is a 3-bit counter with the following rules:
- At a GNT_DMA entry with CPU_REQ=1, RUN SHALL increment, saturating at DMA_MAX_RUN.
- At a GNT_DMA entry with CPU_REQ=0, RUN SHALL clear to 0.
- At a GNT_CPU entry, RUN SHALL clear to 0.
REQ-022 If both masters request simultaneously and RUN=0, DMA SHALL win.
REQ-023 A master dropping REQ while granted SHALL not change state; the transfer still completes on the bus and its BUSY is 0.
REQ-024 CE_F SHALL not affect arbiter state; CE_F is an input only, for phase alignment with slaves that sample reads on CE_F.
REQ-025 A CE_R=0 cycle SHALL hold all registers and SHALL keep the combinational outputs consistent with the held state.

Reset
REQ-026 While RST=1 at a CLK edge, the block SHALL enter IDLE, clear RUN to 0 and clear the CPU/DMA read latches to 0; this SHALL override CE_R.
REQ-027 After reset: IBUS_REQ=0; IBUS_A/DO/BA/WE=0; CPU_DO=DMA_DO=0; x_BUSY=x_REQ.
REQ-028 RST asserted mid-access SHALL abort the grant: IBUS_REQ SHALL drop in the cycle after the reset edge and no read data SHALL be latched.

Verification
REQ-029 Scenario single read: CPU reads 5FFFF90, slave returns 12345678 with no wait -> grant at CE_R#1; DONE at CE_R#2; CPU_DO=12345678 held; CPU_BUSY high for exactly 2 CE_R periods.
REQ-030 Scenario contention: CPU and DMA request together from IDLE -> DMA granted first; CPU granted next.
REQ-031 Scenario starvation: DMA_REQ held high continuously with CPU_REQ high -> exactly 4 DMA grants, then 1 CPU grant, then RUN=0.
REQ-032 Scenario wait states: IBUS_BUSY held 3 CE_R cycles on a DMA write -> state stays GNT_DMA; DMA_BUSY=1 throughout; DONE on the 4th; CPU_DO unchanged.
REQ-033 Scenario unmapped: CPU reads 0000000 with IBUS_ACT=0 -> DONE at the first granted CE_R; CPU_DO=00000000.
REQ-034 Scenario reset mid-access: RST pulsed during a GNT_CPU wait -> IDLE; IBUS_REQ=0; CPU_DO=0; RUN=0.

Source files
------------

// File: rtl/sh7034_ibus_arb_if.sv
// Bus bundle between the CPU/DMAC masters, the arbiter and the shared on-chip peripheral bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sh7034_ibus_arb_if;
    logic [27:0] CPU_A;
    logic [31:0] CPU_DI;
    logic [3:0]  CPU_BA;
    logic        CPU_WE;
    logic        CPU_REQ;
    logic [31:0] CPU_DO;
    logic        CPU_BUSY;

    logic [27:0] DMA_A;
    logic [31:0] DMA_DI;
    logic [3:0]  DMA_BA;
    logic        DMA_WE;
    logic        DMA_REQ;
    logic [31:0] DMA_DO;
    logic        DMA_BUSY;

    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic [31:0] IBUS_DI;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport slave (
        input  CPU_A, CPU_DI, CPU_BA, CPU_WE, CPU_REQ,
        output CPU_DO, CPU_BUSY,
        input  DMA_A, DMA_DI, DMA_BA, DMA_WE, DMA_REQ,
        output DMA_DO, DMA_BUSY,
        output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
        input  IBUS_DI, IBUS_BUSY, IBUS_ACT
    );

    modport master (
        output CPU_A, CPU_DI, CPU_BA, CPU_WE, CPU_REQ,
        input  CPU_DO, CPU_BUSY,
        output DMA_A, DMA_DI, DMA_BA, DMA_WE, DMA_REQ,
        input  DMA_DO, DMA_BUSY,
        input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
        output IBUS_DI, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/sh7034_ibus_arb.sv
// Two-master (CPU, DMAC) non-preemptive arbiter for the SH7034 internal peripheral bus.
// DMAC has priority but is limited to DMA_MAX_RUN back-to-back grants while the CPU waits.
module sh7034_ibus_arb #(
    parameter int DMA_MAX_RUN = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE_R,
    input  logic CE_F,
    sh7034_ibus_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

    localparam logic [2:0] MAX_RUN = 3'(DMA_MAX_RUN);

    state_t      state_reg, state_next;
    logic [2:0]  run_reg, run_next;
    logic [31:0] cpu_lat_reg, cpu_lat_next;
    logic [31:0] dma_lat_reg, dma_lat_next;

    logic        gnt_cpu, gnt_dma, done;
    logic [31:0] rd_data;

    // Slaves that sample on the falling phase need no arbiter involvement.
    logic unused_ce_f;
    assign unused_ce_f = CE_F;

    assign gnt_cpu = (state_reg == GNT_CPU);
    assign gnt_dma = (state_reg == GNT_DMA);
    // Unmapped accesses complete at once so a stray address cannot lock the bus.
    assign done    = CE_R && (gnt_cpu || gnt_dma) && (!bus.IBUS_BUSY || !bus.IBUS_ACT);
    assign rd_data = bus.IBUS_ACT ? bus.IBUS_DI : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            run_reg     <= 3'd0;
            cpu_lat_reg <= 32'h0;
            dma_lat_reg <= 32'h0;
        end else begin
            state_reg   <= state_next;
            run_reg     <= run_next;
            cpu_lat_reg <= cpu_lat_next;
            dma_lat_reg <= dma_lat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        run_next     = run_reg;
        cpu_lat_next = cpu_lat_reg;
        dma_lat_next = dma_lat_reg;
        if (CE_R) begin
            case (state_reg)
                IDLE: begin
                    if (bus.DMA_REQ && ((run_reg < MAX_RUN) || !bus.CPU_REQ)) begin
                        state_next = GNT_DMA;
                        if (!bus.CPU_REQ)
                            run_next = 3'd0;
                        else if (run_reg < MAX_RUN)
                            run_next = run_reg + 3'd1;
                    end else if (bus.CPU_REQ) begin
                        state_next = GNT_CPU;
                        run_next   = 3'd0;
                    end
                end
                GNT_CPU: begin
                    if (done) begin
                        state_next = IDLE;
                        if (!bus.CPU_WE)
                            cpu_lat_next = rd_data;
                    end
                end
                GNT_DMA: begin
                    if (done) begin
                        state_next = IDLE;
                        if (!bus.DMA_WE)
                            dma_lat_next = rd_data;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus outputs follow the granted master combinationally; idle bus is driven to zero.
    assign bus.IBUS_REQ = gnt_cpu || gnt_dma;
    assign bus.IBUS_A   = gnt_cpu ? bus.CPU_A  : gnt_dma ? bus.DMA_A  : 28'h0;
    assign bus.IBUS_DO  = gnt_cpu ? bus.CPU_DI : gnt_dma ? bus.DMA_DI : 32'h0;
    assign bus.IBUS_BA  = gnt_cpu ? bus.CPU_BA : gnt_dma ? bus.DMA_BA : 4'h0;
    assign bus.IBUS_WE  = gnt_cpu ? bus.CPU_WE : gnt_dma ? bus.DMA_WE : 1'b0;

    assign bus.CPU_BUSY = bus.CPU_REQ && !(gnt_cpu && done);
    assign bus.DMA_BUSY = bus.DMA_REQ && !(gnt_dma && done);

    assign bus.CPU_DO = (gnt_cpu && !bus.CPU_WE) ? bus.IBUS_DI : cpu_lat_reg;
    assign bus.DMA_DO = (gnt_dma && !bus.DMA_WE) ? bus.IBUS_DI : dma_lat_reg;
endmodule
